// File: rtl/sc_stream_counter.sv
// Stochastic-to-binary back end: counts 1s of a STREAM_LEN-clock bitstream window.
// Optional bipolar decode (2*ones - STREAM_LEN, signed) is enabled by defining SC_BIPOLAR_EN.
module sc_stream_counter #(
  parameter int STREAM_LEN = 256,
  parameter int CNT_W      = $clog2(STREAM_LEN+1),
`ifdef SC_BIPOLAR_EN
  parameter int RES_W      = CNT_W + 1
`else
  parameter int RES_W      = CNT_W
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_in,
  output logic             stream_en,
  output logic             busy,
  output logic [RES_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cyc_cnt, ones_cnt, ones_sum;
  logic [RES_W-1:0] res_nxt;
  logic             last, accept, start_win;

  assign stream_en    = (state == RUN);
  assign busy         = (state != IDLE);
  assign result_valid = (state == HOLD);

  assign accept    = result_valid & result_ready;
  assign last      = (state == RUN) && (cyc_cnt == CNT_W'(STREAM_LEN-1));
  assign ones_sum  = ones_cnt + CNT_W'(bit_in);
  // Counters clear on every entry into RUN, including back-to-back from HOLD.
  assign start_win = (state_nxt == RUN) && (state != RUN);

`ifdef SC_BIPOLAR_EN
  assign res_nxt = {ones_sum, 1'b0} - RES_W'(STREAM_LEN);
`else
  assign res_nxt = ones_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!abort && start) state_nxt = RUN;
      RUN: begin
        if (abort)     state_nxt = IDLE;
        else if (last) state_nxt = HOLD;
      end
      HOLD: begin
        if (abort)       state_nxt = IDLE;
        else if (accept) state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt  <= '0;
      ones_cnt <= '0;
      result   <= '0;
    end else if (!abort) begin
      if (start_win) begin
        cyc_cnt  <= '0;
        ones_cnt <= '0;
      end else if (state == RUN) begin
        if (last) begin
          result   <= res_nxt;
          cyc_cnt  <= '0;
          ones_cnt <= '0;
        end else begin
          cyc_cnt  <= cyc_cnt + 1'b1;
          ones_cnt <= ones_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_sc_stream_counter.sv
// Directed bench for sc_stream_counter with an expected-result queue.
module tb_sc_stream_counter;
  localparam int L     = 256;
  localparam int CNT_W = $clog2(L+1);
`ifdef SC_BIPOLAR_EN
  localparam int RES_W = CNT_W + 1;
`else
  localparam int RES_W = CNT_W;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0, abort = 1'b0, bit_in = 1'b0, result_ready = 1'b0;
  logic             stream_en, busy, result_valid;
  logic [RES_W-1:0] result;

  logic [RES_W-1:0] sb_q[$];
  logic [RES_W-1:0] last_res, want;
  int               vectors = 0, errors = 0;

  sc_stream_counter #(.STREAM_LEN(L)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bit_in(bit_in),
    .stream_en(stream_en), .busy(busy), .result(result),
    .result_valid(result_valid), .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RES_W-1:0] model(input int ones);
`ifdef SC_BIPOLAR_EN
    int v;
    v = 2*ones - L;
    return RES_W'(v);
`else
    return RES_W'(ones);
`endif
  endfunction

  function automatic logic pat(input int mode, input int i);
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return (i % 2 == 0);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Feed n samples while in RUN; pushes the expected result when a full window is fed.
  task automatic feed(input int mode, input int n, input bit start_pulses, input string tag);
    int ones = 0, en_cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (stream_en) en_cnt++;
      bit_in = pat(mode, i);
      ones  += int'(bit_in);
      start  = start_pulses && (i % 37 == 5);
      if (i == L-1) check({tag, " valid_before_last"}, 32'(result_valid), 32'd0);
      tick();
    end
    start  = 1'b0;
    bit_in = 1'b0;
    check({tag, " stream_en_cycles"}, 32'(en_cnt), 32'(n));
    if (n == L) sb_q.push_back(model(ones));
  endtask

  task automatic open_window(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " run_entered"}, 32'(stream_en), 32'd1);
  endtask

  task automatic expect_result(input string tag);
    int k = 0;
    while (!result_valid && k < 5) begin tick(); k++; end
    check({tag, " valid"}, 32'(result_valid), 32'd1);
    check({tag, " stream_en_off"}, 32'(stream_en), 32'd0);
    if (sb_q.size() == 0) begin
      check({tag, " scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      want     = sb_q.pop_front();
      last_res = want;
      check({tag, " result"}, 32'(result), 32'(want));
    end
  endtask

  task automatic accept_idle(input string tag);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check({tag, " valid_cleared"}, 32'(result_valid), 32'd0);
    check({tag, " idle"}, 32'(busy), 32'd0);
    check({tag, " result_kept"}, 32'(result), 32'(last_res));
  endtask

  initial begin
    #12 rst_n = 1'b1;
    tick();
    check("reset stream_en", 32'(stream_en), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset valid", 32'(result_valid), 32'd0);
    check("reset result", 32'(result), 32'd0);

    // ready while nothing is valid must not disturb IDLE
    result_ready = 1'b1;
    tick(); tick();
    result_ready = 1'b0;
    check("ready_idle busy", 32'(busy), 32'd0);

    // all ones
    open_window("ones");
    feed(1, L, 1'b0, "ones");
    expect_result("ones");
    accept_idle("ones");

    // alternating 1,0
    open_window("alt");
    feed(2, L, 1'b0, "alt");
    expect_result("alt");

    // stall the consumer, then accept with start for a back-to-back window
    for (int c = 0; c < 10; c++) begin
      tick();
      check("stall valid", 32'(result_valid), 32'd1);
      check("stall result", 32'(result), 32'(last_res));
      check("stall stream_en", 32'(stream_en), 32'd0);
    end
    start = 1'b1;
    tick();
    check("stall ignored_start", 32'(result_valid), 32'd1);
    result_ready = 1'b1;
    tick();
    start = 1'b0;
    result_ready = 1'b0;
    check("b2b run_next_cycle", 32'(stream_en), 32'd1);
    check("b2b valid_dropped", 32'(result_valid), 32'd0);
    feed(3, L, 1'b0, "rand");
    expect_result("rand");
    accept_idle("rand");

    // abort at sample 100
    open_window("abort");
    feed(1, 100, 1'b0, "abort");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort idle", 32'(busy), 32'd0);
    check("abort valid", 32'(result_valid), 32'd0);
    check("abort result_kept", 32'(result), 32'(last_res));
    repeat (3) tick();
    check("abort valid_stays_low", 32'(result_valid), 32'd0);

    // asynchronous reset at sample 50, between edges
    open_window("rst");
    feed(1, 50, 1'b0, "rst");
    #2 rst_n = 1'b0;
    #1;
    check("rst_async stream_en", 32'(stream_en), 32'd0);
    check("rst_async busy", 32'(busy), 32'd0);
    check("rst_async valid", 32'(result_valid), 32'd0);
    check("rst_async result", 32'(result), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    open_window("post_rst");
    feed(1, L, 1'b0, "post_rst");
    expect_result("post_rst");
    accept_idle("post_rst");

    // all zeros with start pulses during RUN
    open_window("zeros");
    feed(0, L, 1'b1, "zeros");
    expect_result("zeros");
    accept_idle("zeros");

    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
